dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the data-memory responder  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam int DATA_W          = 32;
    localparam int BE_W            = 4;
    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array : byte-enabled word array, synchronous write, comb read   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   byte_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byte_en[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : fixed-latency request/response data-memory slave    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    input  logic              Wr,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [BE_W-1:0]   ByteEn,
    output logic              Ready,
    output logic              Done,
    output logic [DATA_W-1:0] RdData,
    output logic              Err
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [31:0]      DEPTH_U  = DEPTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    logic               req_wr;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;
    logic [DATA_W-1:0]  req_data;
    logic [BE_W-1:0]    req_be;

    logic               accept;
    logic               addr_err;
    logic               commit_we;
    logic [IDX_W-1:0]   commit_idx;
    logic [DATA_W-1:0]  commit_data;
    logic [BE_W-1:0]    commit_be;
    logic [DATA_W-1:0]  rd_word;

    assign Ready    = (state != ST_WAIT);
    assign accept   = Req && Ready;
    assign addr_err = (Addr[1:0] != 2'b00) || ({2'b00, Addr[31:2]} >= DEPTH_U);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else if (state == ST_RESP) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            req_wr   <= 1'b0;
            req_err  <= 1'b0;
            req_idx  <= '0;
            req_data <= '0;
            req_be   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                req_wr   <= Wr;
                req_err  <= addr_err;
                req_idx  <= Addr[IDX_W+1:2];
                req_data <= WrData;
                req_be   <= ByteEn;
            end
        end
    end

    // Writes land on the edge entering RESP; with single-cycle latency that is the accept edge itself.
    generate
        if (LATENCY == 1) begin : g_commit_direct
            assign commit_we   = accept && Wr && !addr_err;
            assign commit_idx  = Addr[IDX_W+1:2];
            assign commit_data = WrData;
            assign commit_be   = ByteEn;
        end else begin : g_commit_captured
            assign commit_we   = (state == ST_WAIT) && (cnt == '0) && req_wr && !req_err;
            assign commit_idx  = req_idx;
            assign commit_data = req_data;
            assign commit_be   = req_be;
        end
    endgenerate

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (Clk),
        .rst_n   (Rst),
        .we      (commit_we),
        .wr_idx  (commit_idx),
        .wr_data (commit_data),
        .byte_en (commit_be),
        .rd_idx  (req_idx),
        .rd_data (rd_word)
    );

    assign Done   = (state == ST_RESP);
    assign Err    = Done && req_err;
    assign RdData = (Done && !req_wr && !req_err) ? rd_word : '0;

endmodule
`default_nettype wire
